// File: rtl/netlist_bist_sequencer_if.sv
// Stimulus/response and status bundle between the BIST sequencer and its controller.
// master: controller plus netlist side; slave: the sequencer.
interface netlist_bist_sequencer_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 3
) ();
    logic             start;
    logic [IN_W-1:0]  pat;
    logic [OUT_W-1:0] resp;
    logic             busy;
    logic             done;
    logic [15:0]      sig;
    logic             pass;

    modport master (
        output start, resp,
        input  pat, busy, done, sig, pass
    );

    modport slave (
        input  start, resp,
        output pat, busy, done, sig, pass
    );
endinterface

// File: rtl/netlist_bist_sequencer.sv
// BIST sequencer: drives patterns into a netlist and compacts responses into a 16-bit MISR.
// Define PATTERN_LFSR_EN for LFSR stimulus instead of the default counter.
module netlist_bist_sequencer #(
    parameter int          IN_W    = 3,
    parameter int          OUT_W   = 3,
    parameter int          NUM_PAT = 8,
    parameter logic [15:0] GOLDEN  = 16'h0000
) (
    input logic clk,
    input logic rst,
    netlist_bist_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PAT) + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IN_W-1:0]  pat_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [15:0]      sig_q;
    logic [15:0]      sig_nxt;
    logic [IN_W-1:0]  pat_first;
    logic [IN_W-1:0]  pat_step;

    assign sig_nxt = {sig_q[14:0],
                      sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]}
                     ^ 16'(bus.resp);

`ifdef PATTERN_LFSR_EN
    localparam logic [15:0] SEED = 16'hACE1;

    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;

    assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign pat_first = SEED[IN_W-1:0];
    assign pat_step  = lfsr_nxt[IN_W-1:0];

    // Advances only when idx does, so pattern k is always lfsr after k steps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (state == IDLE && bus.start) begin
            lfsr <= SEED;
        end else if (state == RUN && idx != LAST) begin
            lfsr <= lfsr_nxt;
        end
    end
`else
    // pat tracks idx modulo 2^IN_W, so a plain increment wraps correctly
    assign pat_first = '0;
    assign pat_step  = pat_q + IN_W'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            pat_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sig_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        idx    <= '0;
                        pat_q  <= pat_first;
                        busy_q <= 1'b1;
                        sig_q  <= '0;
                        pass_q <= 1'b0;
                    end
                end
                RUN: begin
                    sig_q <= sig_nxt;
                    if (idx == LAST) begin
                        state  <= FINISH;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        // Compare the final signature so pass is valid with done
                        pass_q <= (sig_nxt == GOLDEN);
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        pat_q <= pat_step;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pat  = pat_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sig  = sig_q;
    assign bus.pass = pass_q;
endmodule

// File: tb/tb_netlist_bist_sequencer.sv
// Directed bench for netlist_bist_sequencer: counter/LFSR stimulus,
// MISR compaction, pass/fail, ignored starts, mid-run reset, pattern wrap.
module tb_netlist_bist_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    netlist_bist_sequencer_if #(.IN_W(3), .OUT_W(3)) if0 ();
    netlist_bist_sequencer_if #(.IN_W(3), .OUT_W(3)) if1 ();
    netlist_bist_sequencer_if #(.IN_W(3), .OUT_W(3)) if2 ();
    netlist_bist_sequencer_if #(.IN_W(3), .OUT_W(3)) if3 ();

    netlist_bist_sequencer #(.IN_W(3), .OUT_W(3), .NUM_PAT(8), .GOLDEN(16'h0000))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    netlist_bist_sequencer #(.IN_W(3), .OUT_W(3), .NUM_PAT(2), .GOLDEN(16'h0003))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    netlist_bist_sequencer #(.IN_W(3), .OUT_W(3), .NUM_PAT(2), .GOLDEN(16'h0004))
        dut2 (.clk(clk), .rst(rst), .bus(if2));
    netlist_bist_sequencer #(.IN_W(3), .OUT_W(3), .NUM_PAT(20), .GOLDEN(16'h0000))
        dut3 (.clk(clk), .rst(rst), .bus(if3));

    // Stand-in netlist for dut3
    assign if3.resp = if3.pat ^ 3'b101;

    function automatic logic [2:0] exp_pat(input int k);
`ifdef PATTERN_LFSR_EN
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < k; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return l[2:0];
`else
        return 3'(k % 8);
`endif
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++; if (if0.pat !== 3'd0) begin failures++; $display("FAIL rst_pat got=%h want=0", if0.pat); end
        checks++; if (if0.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", if0.busy); end
        checks++; if (if0.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", if0.done); end
        checks++; if (if0.sig !== 16'h0000) begin failures++; $display("FAIL rst_sig got=%h want=0000", if0.sig); end
        checks++; if (if0.pass !== 1'b0) begin failures++; $display("FAIL rst_pass got=%b want=0", if0.pass); end
        checks++; if (if3.sig !== 16'h0000) begin failures++; $display("FAIL rst_sig3 got=%h want=0000", if3.sig); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (if0.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", if0.busy); end
    endtask

    task automatic test_counter();
        if0.resp = 3'b000;
        @(negedge clk); if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (if0.pat !== exp_pat(k)) begin failures++; $display("FAIL cnt_pat%0d got=%h want=%h", k, if0.pat, exp_pat(k)); end
            checks++; if (if0.busy !== 1'b1) begin failures++; $display("FAIL cnt_busy%0d got=%b want=1", k, if0.busy); end
            checks++; if (if0.done !== 1'b0) begin failures++; $display("FAIL cnt_done%0d got=%b want=0", k, if0.done); end
            @(negedge clk);
        end
        checks++; if (if0.done !== 1'b1) begin failures++; $display("FAIL cnt_done_pulse got=%b want=1", if0.done); end
        checks++; if (if0.busy !== 1'b0) begin failures++; $display("FAIL cnt_busy_end got=%b want=0", if0.busy); end
        checks++; if (if0.sig !== 16'h0000) begin failures++; $display("FAIL cnt_sig got=%h want=0000", if0.sig); end
        checks++; if (if0.pass !== 1'b1) begin failures++; $display("FAIL cnt_pass got=%b want=1", if0.pass); end
        @(negedge clk);
        checks++; if (if0.done !== 1'b0) begin failures++; $display("FAIL cnt_done_clr got=%b want=0", if0.done); end
        checks++; if (if0.pass !== 1'b1) begin failures++; $display("FAIL cnt_pass_hold got=%b want=1", if0.pass); end
    endtask

    task automatic test_short();
        if1.resp = 3'b001;
        if2.resp = 3'b001;
        @(negedge clk); if1.start = 1'b1; if2.start = 1'b1;
        @(negedge clk); if1.start = 1'b0; if2.start = 1'b0;
        checks++; if (if1.busy !== 1'b1) begin failures++; $display("FAIL sh_busy got=%b want=1", if1.busy); end
        @(negedge clk);
        checks++; if (if1.sig !== 16'h0001) begin failures++; $display("FAIL sh_sig1 got=%h want=0001", if1.sig); end
        @(negedge clk);
        checks++; if (if1.sig !== 16'h0003) begin failures++; $display("FAIL sh_sig2 got=%h want=0003", if1.sig); end
        checks++; if (if1.done !== 1'b1) begin failures++; $display("FAIL sh_done got=%b want=1", if1.done); end
        checks++; if (if1.pass !== 1'b1) begin failures++; $display("FAIL sh_pass_good got=%b want=1", if1.pass); end
        checks++; if (if2.sig !== 16'h0003) begin failures++; $display("FAIL sh_sig_b got=%h want=0003", if2.sig); end
        checks++; if (if2.pass !== 1'b0) begin failures++; $display("FAIL sh_pass_bad got=%b want=0", if2.pass); end
        @(negedge clk);
        checks++; if (if1.done !== 1'b0) begin failures++; $display("FAIL sh_done_clr got=%b want=0", if1.done); end
        checks++; if (if1.pass !== 1'b1) begin failures++; $display("FAIL sh_pass_hold got=%b want=1", if1.pass); end
    endtask

    task automatic test_start_ignored();
        int dones_a = 0;
        int dones_b = 0;
        if0.resp = 3'b001;
        for (int c = 0; c <= 19; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 10 && if0.done === 1'b1) dones_a++;
            if (c >= 11 && if0.done === 1'b1) dones_b++;
            if (c == 3) begin
                checks++; if (if0.sig !== 16'h0003) begin failures++; $display("FAIL ign_sig3 got=%h want=0003", if0.sig); end
                checks++; if (if0.pat !== exp_pat(2)) begin failures++; $display("FAIL ign_pat3 got=%h want=%h", if0.pat, exp_pat(2)); end
            end
            if (c == 9) begin
                checks++; if (if0.done !== 1'b1) begin failures++; $display("FAIL ign_done got=%b want=1", if0.done); end
                checks++; if (if0.sig !== 16'h00FF) begin failures++; $display("FAIL ign_sig got=%h want=00ff", if0.sig); end
                checks++; if (if0.pass !== 1'b0) begin failures++; $display("FAIL ign_pass got=%b want=0", if0.pass); end
            end
            if (c == 11) begin
                checks++; if (if0.busy !== 1'b1) begin failures++; $display("FAIL rerun_busy got=%b want=1", if0.busy); end
                checks++; if (if0.sig !== 16'h0000) begin failures++; $display("FAIL rerun_sig got=%h want=0000", if0.sig); end
                checks++; if (if0.pat !== exp_pat(0)) begin failures++; $display("FAIL rerun_pat got=%h want=%h", if0.pat, exp_pat(0)); end
            end
            if (c == 19) begin
                checks++; if (if0.sig !== 16'h00FF) begin failures++; $display("FAIL rerun_sig_end got=%h want=00ff", if0.sig); end
            end
            if0.start = (c == 0 || c == 2 || c == 9 || c == 10);
        end
        checks++; if (dones_a !== 1) begin failures++; $display("FAIL ign_done_count got=%0d want=1", dones_a); end
        checks++; if (dones_b !== 1) begin failures++; $display("FAIL rerun_done_count got=%0d want=1", dones_b); end
    endtask

    task automatic test_reset_midrun();
        int dones = 0;
        int busys = 0;
        if0.resp = 3'b001;
        @(negedge clk); if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (if0.sig !== 16'h0007) begin failures++; $display("FAIL mid_sig got=%h want=0007", if0.sig); end
        rst = 1'b1;
        #1;
        checks++; if (if0.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b want=0", if0.busy); end
        checks++; if (if0.pat !== 3'd0) begin failures++; $display("FAIL mid_pat got=%h want=0", if0.pat); end
        checks++; if (if0.sig !== 16'h0000) begin failures++; $display("FAIL mid_sig_clr got=%h want=0000", if0.sig); end
        checks++; if (if0.pass !== 1'b0) begin failures++; $display("FAIL mid_pass got=%b want=0", if0.pass); end
        @(negedge clk); rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (if0.done === 1'b1) dones++;
            if (if0.busy === 1'b1) busys++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL mid_no_done got=%0d want=0", dones); end
        checks++; if (busys !== 0) begin failures++; $display("FAIL mid_no_busy got=%0d want=0", busys); end
    endtask

    task automatic test_wrap();
        logic [15:0] msig;
        logic [2:0]  r;
        msig = 16'h0000;
        @(negedge clk); if3.start = 1'b1;
        @(negedge clk); if3.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checks++; if (if3.pat !== exp_pat(k)) begin failures++; $display("FAIL wrap_pat%0d got=%h want=%h", k, if3.pat, exp_pat(k)); end
            checks++; if (if3.sig !== msig) begin failures++; $display("FAIL wrap_sig%0d got=%h want=%h", k, if3.sig, msig); end
            r = exp_pat(k) ^ 3'b101;
            msig = {msig[14:0], msig[15] ^ msig[13] ^ msig[12] ^ msig[10]} ^ {13'd0, r};
            @(negedge clk);
        end
        checks++; if (if3.done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b want=1", if3.done); end
        checks++; if (if3.sig !== msig) begin failures++; $display("FAIL wrap_sig_end got=%h want=%h", if3.sig, msig); end
        checks++; if (if3.pass !== (msig == 16'h0000)) begin failures++; $display("FAIL wrap_pass got=%b want=%b", if3.pass, (msig == 16'h0000)); end
    endtask

    initial begin
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0; if3.start = 1'b0;
        if0.resp = 3'b000; if1.resp = 3'b000; if2.resp = 3'b000;
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_counter();
        test_short();
        test_start_ignored();
        test_reset_midrun();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
